nios_onchip_memory_dp: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) for the Nios subsystem. Generalises the single-port 128-bit/2048-word memory in width, depth and output registering, and adds pipelined `readdatavalid`, a defined cross-port collision rule and an optional zero-fill sequencer after reset. Sits on the Nios data/instruction interconnect, with s2 typically attached to a DMA or accelerator master.

---
 rtl/nios_onchip_memory_dp_pkg.sv | 19 +
 rtl/nios_onchip_memory_dp_if.sv | 25 ++
 rtl/nios_mem_rd_pipe.sv | 50 +++++
 rtl/nios_onchip_memory_dp.sv | 97 +++++++++
 tb/tb_nios_onchip_memory_dp.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_onchip_memory_dp_pkg.sv
// rtl/nios_onchip_memory_dp_pkg.sv - shared types and helpers for the dual-port on-chip RAM
package nios_mem_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } mem_state_t;

  localparam int BYTE_W = 8;

  function automatic int rd_latency(input int outreg);
    return 1 + outreg;
  endfunction

  function automatic int n_lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/nios_onchip_memory_dp_if.sv
// rtl/nios_onchip_memory_dp_if.sv - one Avalon-MM memory port
interface nios_onchip_memory_dp_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_mem_rd_pipe.sv
// rtl/nios_mem_rd_pipe.sv - read response valid/data pipeline, depth 1+OUTREG
module nios_mem_rd_pipe
  import nios_mem_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int OUTREG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  localparam int DEPTH = rd_latency(OUTREG);

  // in_data is the RAM's registered output, so it aligns with v0, not in_valid
  logic v0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0 <= 1'b0;
    end else if (clken) begin
      v0 <= in_valid;
    end
  end

  if (DEPTH == 1) begin : g_direct
    assign out_valid = v0;
    assign out_data  = v0 ? in_data : '0;
  end else begin : g_outreg
    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else if (clken) begin
        v1 <= v0;
        d1 <= v0 ? in_data : '0;
      end
    end

    assign out_valid = v1;
    assign out_data  = d1;
  end

endmodule

// File: rtl/nios_onchip_memory_dp.sv
// rtl/nios_onchip_memory_dp.sv - true dual-port on-chip RAM with zero-fill after reset
module nios_onchip_memory_dp
  import nios_mem_pkg::*;
#(
  parameter int    DATA_W         = 128,
  parameter int    ADDR_W         = 11,
  parameter int    OUTREG         = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "nios_onchip_memory_dp.hex"
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clken,
  nios_onchip_memory_dp_if.slave    s1,
  nios_onchip_memory_dp_if.slave    s2
);
  localparam int LANES = n_lanes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q1;
  logic [DATA_W-1:0] ram_q2;

  mem_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wait_req;
  logic              clr_we;
  logic              cmd1, cmd2;
  logic              wr1, wr2;
  logic              rd1, rd2;

  assign wait_req = (state == CLEAR) | ~clken | ~reset_n;
  assign clr_we   = reset_n & clken & (state == CLEAR);

  assign s1.waitrequest = wait_req;
  assign s2.waitrequest = wait_req;

  // A read issued together with a write on the same port is dropped
  assign cmd1 = s1.chipselect & ~wait_req;
  assign cmd2 = s2.chipselect & ~wait_req;
  assign wr1  = cmd1 & s1.write;
  assign wr2  = cmd2 & s2.write;
  assign rd1  = cmd1 & s1.read & ~s1.write;
  assign rd2  = cmd2 & s2.read & ~s2.write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
    end else if (clken && state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state <= RUN;
      end
    end
  end

  // Reads see pre-write contents; s1 lanes are assigned last so s1 wins overlaps
  always_ff @(posedge clk) begin
    if (clken) begin
      ram_q1 <= mem[s1.address];
      ram_q2 <= mem[s2.address];
    end
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (wr2 && s2.byteenable[l]) begin
        mem[s2.address][l*BYTE_W +: BYTE_W] <= s2.writedata[l*BYTE_W +: BYTE_W];
      end
      if (wr1 && s1.byteenable[l]) begin
        mem[s1.address][l*BYTE_W +: BYTE_W] <= s1.writedata[l*BYTE_W +: BYTE_W];
      end
    end
  end

  nios_mem_rd_pipe #(.DATA_W(DATA_W), .OUTREG(OUTREG)) u_pipe1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_valid  (rd1),
    .in_data   (ram_q1),
    .out_valid (s1.readdatavalid),
    .out_data  (s1.readdata)
  );

  nios_mem_rd_pipe #(.DATA_W(DATA_W), .OUTREG(OUTREG)) u_pipe2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_valid  (rd2),
    .in_data   (ram_q2),
    .out_valid (s2.readdatavalid),
    .out_data  (s2.readdata)
  );

endmodule

// File: tb/tb_nios_onchip_memory_dp.sv
// tb/tb_nios_onchip_memory_dp.sv - self-checking bench for nios_onchip_memory_dp
module tb_nios_onchip_memory_dp;

  logic clk;
  logic reset_n;
  logic clken;

  logic         p_cs [2];
  logic         p_rd [2];
  logic         p_wr [2];
  logic [3:0]   p_addr [2];
  logic [15:0]  p_be [2];
  logic [127:0] p_wd [2];

  nios_onchip_memory_dp_if #(.DATA_W(128), .ADDR_W(4)) a1 ();
  nios_onchip_memory_dp_if #(.DATA_W(128), .ADDR_W(4)) a2 ();
  nios_onchip_memory_dp_if #(.DATA_W(128), .ADDR_W(4)) b1 ();
  nios_onchip_memory_dp_if #(.DATA_W(128), .ADDR_W(4)) b2 ();

  assign a1.chipselect = p_cs[0];   assign b1.chipselect = p_cs[0];
  assign a1.read       = p_rd[0];   assign b1.read       = p_rd[0];
  assign a1.write      = p_wr[0];   assign b1.write      = p_wr[0];
  assign a1.address    = p_addr[0]; assign b1.address    = p_addr[0];
  assign a1.byteenable = p_be[0];   assign b1.byteenable = p_be[0];
  assign a1.writedata  = p_wd[0];   assign b1.writedata  = p_wd[0];
  assign a2.chipselect = p_cs[1];   assign b2.chipselect = p_cs[1];
  assign a2.read       = p_rd[1];   assign b2.read       = p_rd[1];
  assign a2.write      = p_wr[1];   assign b2.write      = p_wr[1];
  assign a2.address    = p_addr[1]; assign b2.address    = p_addr[1];
  assign a2.byteenable = p_be[1];   assign b2.byteenable = p_be[1];
  assign a2.writedata  = p_wd[1];   assign b2.writedata  = p_wd[1];

  nios_onchip_memory_dp #(
    .DATA_W(128), .ADDR_W(4), .OUTREG(0), .CLEAR_ON_RESET(1),
    .INIT_FILE("nios_onchip_memory_dp.hex")
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .s1(a1), .s2(a2)
  );

  nios_onchip_memory_dp #(
    .DATA_W(128), .ADDR_W(4), .OUTREG(1), .CLEAR_ON_RESET(1),
    .INIT_FILE("nios_onchip_memory_dp.hex")
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .s1(b1), .s2(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array, clear countdown, responses keyed by enabled-edge index
  logic [127:0] mem_m [16];
  logic [127:0] rsp0 [int];
  logic [127:0] rsp1 [int];
  int           ecount;
  int           clear_left;
  bit           en_edge;
  int           n_vec;
  int           n_bad;

  typedef struct {
    int           op1;
    int           op2;
    logic [3:0]   ad1;
    logic [3:0]   ad2;
    logic [15:0]  be1;
    logic [15:0]  be2;
    logic [127:0] wd1;
    logic [127:0] wd2;
    int           chk;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [9];

  function automatic void cmp(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit has_rsp(int p, int key);
    return (p == 0) ? rsp0.exists(key) : rsp1.exists(key);
  endfunction

  function automatic logic [127:0] get_rsp(int p, int key);
    return (p == 0) ? rsp0[key] : rsp1[key];
  endfunction

  task automatic check_port(string nm, int p, int lat, logic v, logic [127:0] d);
    int key;
    bit ev;
    key = ecount - lat + 1;
    ev  = has_rsp(p, key);
    cmp({nm, "_valid"}, {127'd0, v}, {127'd0, ev});
    if (ev) cmp({nm, "_data"}, d, get_rsp(p, key));
    if (!reset_n) cmp({nm, "_rst_data"}, d, '0);
  endtask

  task automatic check_outputs();
    logic ew;
    ew = (clear_left > 0) || !clken || !reset_n;
    cmp("d0_s1_waitreq", {127'd0, a1.waitrequest}, {127'd0, ew});
    cmp("d0_s2_waitreq", {127'd0, a2.waitrequest}, {127'd0, ew});
    cmp("d1_s1_waitreq", {127'd0, b1.waitrequest}, {127'd0, ew});
    cmp("d1_s2_waitreq", {127'd0, b2.waitrequest}, {127'd0, ew});
    check_port("d0_s1", 0, 1, a1.readdatavalid, a1.readdata);
    check_port("d0_s2", 1, 1, a2.readdatavalid, a2.readdata);
    check_port("d1_s1", 0, 2, b1.readdatavalid, b1.readdata);
    check_port("d1_s2", 1, 2, b2.readdatavalid, b2.readdata);
  endtask

  task automatic tick();
    bit           wreq;
    bit           acc;
    bit           w [2];
    bit           r [2];
    logic [127:0] old [2];
    wreq = (clear_left > 0) || !clken || !reset_n;
    for (int p = 0; p < 2; p++) begin
      acc    = p_cs[p] && (p_rd[p] || p_wr[p]) && !wreq;
      w[p]   = acc && p_wr[p];
      r[p]   = acc && p_rd[p] && !p_wr[p];
      old[p] = mem_m[p_addr[p]];
    end
    en_edge = clken;
    @(posedge clk);
    if (!reset_n) begin
      clear_left = 16;
      rsp0.delete();
      rsp1.delete();
    end else if (clken) begin
      ecount++;
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          for (int i = 0; i < 16; i++) mem_m[i] = '0;
        end
      end
      for (int p = 1; p >= 0; p--) begin
        if (w[p]) begin
          for (int l = 0; l < 16; l++) begin
            if (p_be[p][l]) mem_m[p_addr[p]][l*8 +: 8] = p_wd[p][l*8 +: 8];
          end
        end
      end
      if (r[0]) rsp0[ecount] = old[0];
      if (r[1]) rsp1[ecount] = old[1];
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(int p, int op, logic [3:0] a, logic [15:0] be, logic [127:0] wd);
    p_cs[p]   = (op != 0);
    p_rd[p]   = (op == 1) || (op == 3);
    p_wr[p]   = (op >= 2);
    p_addr[p] = a;
    p_be[p]   = be;
    p_wd[p]   = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nresp;
    int last_t;
    n_vec      = 0;
    n_bad      = 0;
    ecount     = 0;
    clear_left = 16;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    clken   = 1'b1;
    reset_n = 1'b0;
    drive(0, 0, 4'd0, 16'h0, '0);
    drive(1, 0, 4'd0, 16'h0, '0);

    tbl[0] = '{2, 0, 4'd3, 4'd0, 16'h000F, 16'h0, {16{8'hA5}}, '0, 0, '0};
    tbl[1] = '{1, 0, 4'd3, 4'd0, 16'h0, 16'h0, '0, '0, 1, {96'd0, 32'hA5A5A5A5}};
    tbl[2] = '{2, 2, 4'd7, 4'd7, 16'h00FF, 16'h0FF0, {16{8'h11}}, {16{8'h22}}, 0, '0};
    tbl[3] = '{1, 0, 4'd7, 4'd0, 16'h0, 16'h0, '0, '0, 1,
               {32'd0, 32'h22222222, 64'h1111111111111111}};
    tbl[4] = '{2, 0, 4'd5, 4'd0, 16'hFFFF, 16'h0, 128'hCAFE, '0, 0, '0};
    tbl[5] = '{2, 1, 4'd5, 4'd5, 16'hFFFF, 16'h0, 128'hDEAD, '0, 2, 128'hCAFE};
    tbl[6] = '{0, 1, 4'd0, 4'd5, 16'h0, 16'h0, '0, '0, 2, 128'hDEAD};
    tbl[7] = '{3, 0, 4'd9, 4'd0, 16'hFFFF, 16'h0, 128'h1234, '0, 0, '0};
    tbl[8] = '{1, 0, 4'd9, 4'd0, 16'h0, 16'h0, '0, '0, 1, 128'h1234};

    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    n = 0;
    while (a1.waitrequest === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    cmp("clear_cycles", n, 16);

    // Cleared words read back as zero, one cycle after each command
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, i[3:0], 16'h0, '0);
      tick();
      cmp("clear_word_valid", {127'd0, a1.readdatavalid}, 128'd1);
      cmp("clear_word_data", a1.readdata, '0);
    end
    drive(0, 0, 4'd0, 16'h0, '0);
    tick();

    for (int k = 0; k < 9; k++) begin
      drive(0, tbl[k].op1, tbl[k].ad1, tbl[k].be1, tbl[k].wd1);
      drive(1, tbl[k].op2, tbl[k].ad2, tbl[k].be2, tbl[k].wd2);
      tick();
      drive(0, 0, 4'd0, 16'h0, '0);
      drive(1, 0, 4'd0, 16'h0, '0);
      if (tbl[k].chk == 1) begin
        cmp("tbl_s1_valid", {127'd0, a1.readdatavalid}, 128'd1);
        cmp("tbl_s1_data", a1.readdata, tbl[k].exp);
      end else if (tbl[k].chk == 2) begin
        cmp("tbl_s2_valid", {127'd0, a2.readdatavalid}, 128'd1);
        cmp("tbl_s2_data", a2.readdata, tbl[k].exp);
      end
    end
    tick();

    // Back-to-back burst with a 3-cycle clock-enable gap in the middle
    nresp  = 0;
    last_t = 0;
    n      = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, i[3:0], 16'h0, '0);
      drive(1, 1, 4'(15 - i), 16'h0, '0);
      if (i == 4) begin
        clken = 1'b0;
        repeat (3) begin
          tick();
          n++;
          if (en_edge && b1.readdatavalid) begin nresp++; last_t = n; end
        end
        clken = 1'b1;
      end
      tick();
      n++;
      if (en_edge && b1.readdatavalid) begin nresp++; last_t = n; end
    end
    drive(0, 0, 4'd0, 16'h0, '0);
    drive(1, 0, 4'd0, 16'h0, '0);
    repeat (3) begin
      tick();
      n++;
      if (en_edge && b1.readdatavalid) begin nresp++; last_t = n; end
    end
    cmp("burst_resp_count", nresp, 8);
    cmp("burst_last_cycle", last_t, 12);

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        drive(p, $urandom_range(0, 3), 4'($urandom_range(0, 15)), 16'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(0, 5) == 0) p_cs[p] = 1'b0;
      end
      clken = ($urandom_range(0, 7) != 0);
      tick();
    end
    clken = 1'b1;

    // Reads in flight at reset, then reset again part-way through CLEAR
    drive(0, 1, 4'd2, 16'h0, '0);
    drive(1, 1, 4'd3, 16'h0, '0);
    tick();
    drive(0, 0, 4'd0, 16'h0, '0);
    drive(1, 0, 4'd0, 16'h0, '0);
    reset_n = 1'b0;
    tick();
    cmp("flush_d1_s1", {127'd0, b1.readdatavalid}, '0);
    cmp("flush_d1_s2", {127'd0, b2.readdatavalid}, '0);
    reset_n = 1'b1;
    drive(0, 1, 4'd1, 16'h0, '0);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    n = 0;
    while (a1.waitrequest === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    cmp("reclear_cycles", n, 16);
    drive(0, 0, 4'd0, 16'h0, '0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
